tug_game_ctrl: RTL and testbench
================================

TUG_GAME_CTRL -- requirements
Module: tug_game_ctrl

Interface
REQ-001 Parameter TICK_CYCLES, default 48000000, clk cycles per countdown/GO step (1 s at 48 MHz).
REQ-002 Parameter DEBOUNCE_CYCLES, default 240000, cycles a synchronized button level must hold stable before it is accepted (used only under DEBOUNCE_EN).
REQ-003 clk  input  1  single system clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  raw asynchronous start button, active-high.
REQ-006 p1_btn  input  1  raw asynchronous player-1 button, active-high.
REQ-007 p2_btn  input  1  raw asynchronous player-2 button, active-high.
REQ-008 screen  output  6  registered screen code for the display driver: 0 blank, 16 P1 wins, 17..29 rope position, 30 P2 wins, 31 GO, 32 "1", 33 "2", 34 "3".

Function
REQ-009 Each raw input SHALL pass through a 2-flop synchronizer; a press SHALL be the single-cycle rising edge of the synchronized (or debounced) level.
REQ-010 States SHALL be IDLE, CNT3, CNT2, CNT1, GO, PLAY, P1WIN, P2WIN; screen is 0, 34, 33, 32, 31, position, 16 and 30 respectively.
REQ-011 IDLE -> CNT3 on start press; P1WIN or P2WIN -> CNT3 on start press; start presses in any other state SHALL be ignored.
REQ-012 CNT3 -> CNT2 -> CNT1 -> GO -> PLAY, each state held exactly TICK_CYCLES cycles, timed by a tick counter cleared on every state entry.
REQ-013 Entering CNT3 SHALL set position to 23 (centre).
REQ-014 Player presses SHALL be ignored in all states except PLAY.
REQ-015 In PLAY: p1 press alone decrements position by 1; p2 press alone increments by 1; both in the same cycle leave position unchanged.
REQ-016 Position reaching 16 SHALL enter P1WIN; reaching 30 SHALL enter P2WIN; position SHALL never leave 16..30.
REQ-017 screen SHALL reflect a state/position change on the clock edge at which the change occurs (no extra output stage).
REQ-018 Without DEBOUNCE_EN, a press SHALL change screen on the 3rd rising clk edge counting the first edge that samples the raw input high as the 1st.
REQ-019 A held button SHALL produce exactly one press; release and re-press is required for another.
REQ-020 Tick counter SHALL be wide enough for TICK_CYCLES-1 and wrap to 0 only on state exit.

Reset
REQ-021 On reset assertion, immediately and asynchronously: state IDLE, screen 0, position 23, tick counter 0, synchronizer/edge/debounce registers 0.
REQ-022 Reset asserted mid-countdown or mid-game SHALL abandon it; after release, behaviour is identical to power-up.
REQ-023 A button held high through reset release SHALL NOT generate a press until released and pressed again.

Configuration
REQ-024 Macro TUG_DEBOUNCE_EN: when defined, each synchronized input feeds a debounce counter; level accepted only after DEBOUNCE_CYCLES consecutive identical samples, press latency becomes REQ-018 latency + DEBOUNCE_CYCLES.
REQ-025 When TUG_DEBOUNCE_EN is undefined, no debounce logic SHALL be synthesized and REQ-018 latency applies.

Verification (TICK_CYCLES=10, DEBOUNCE_CYCLES=4)
REQ-026 Reset, then start press -> screen 34, 33, 32, 31 for 10 cycles each, then 23.
REQ-027 In PLAY at 23, seven p1 presses -> screen 22..17 then 16, further p1/p2 presses ignored, screen stays 16.
REQ-028 In PLAY, p1 and p2 rising in same cycle -> screen unchanged; p2 held 50 cycles -> exactly +1.
REQ-029 p1 presses during CNT2 and GO -> screen still 23 on entering PLAY.
REQ-030 Reset asserted during PLAY at 27 -> screen 0 asynchronously; after release, p2 press -> stays 0; start -> 34.
REQ-031 With TUG_DEBOUNCE_EN, 3-cycle glitch on p2_btn -> no move; 6-cycle pulse -> +1 exactly.

Source files
------------

// File: rtl/tug_game_ctrl.sv
// Tug-of-war game controller: button conditioning, countdown and rope-position FSM.
// Define TUG_DEBOUNCE_EN to add a per-button debounce stage after the synchronizer.
module tug_btn_cond
`ifdef TUG_DEBOUNCE_EN
  #(parameter int DB_CYC = 4)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  input  logic settled_i,
  output logic press_o
);
  logic [1:0] sync_q;
  logic       lvl;
  logic       prev_q;
  logic       arm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], btn_i};
  end

`ifdef TUG_DEBOUNCE_EN
  localparam int DW = (DB_CYC > 1) ? $clog2(DB_CYC + 1) : 1;
  logic [DW-1:0] cnt_q;
  logic          db_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else if (sync_q[1] == db_q) begin
      cnt_q <= '0;
    end else if (cnt_q == DW'(DB_CYC - 1)) begin
      db_q  <= sync_q[1];
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
  assign lvl = db_q;
`else
  assign lvl = sync_q[1];
`endif

  // Arm only after a genuine low level is seen once the pipeline holds real samples,
  // so a button held through reset release never counts as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      prev_q <= lvl;
      arm_q  <= arm_q | (settled_i & ~lvl);
    end
  end

  assign press_o = lvl & ~prev_q & arm_q;
endmodule

module tug_game_ctrl #(
  parameter int TICK_CYCLES     = 48000000,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_btn,
  input  logic       p2_btn,
  output logic [5:0] screen
);
  localparam int NUM_LANES = 3;
  localparam int TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
`ifdef TUG_DEBOUNCE_EN
  localparam int DB_CYC = DEBOUNCE_CYCLES;
`else
  localparam int DB_CYC = 0 * DEBOUNCE_CYCLES;
`endif
  localparam int SETTLE = 2 + DB_CYC;
  localparam int SW     = $clog2(SETTLE + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CNT3  = 3'd1;
  localparam logic [2:0] S_CNT2  = 3'd2;
  localparam logic [2:0] S_CNT1  = 3'd3;
  localparam logic [2:0] S_GO    = 3'd4;
  localparam logic [2:0] S_PLAY  = 3'd5;
  localparam logic [2:0] S_P1WIN = 3'd6;
  localparam logic [2:0] S_P2WIN = 3'd7;

  logic [NUM_LANES-1:0] raw;
  logic [NUM_LANES-1:0] press;
  logic [SW-1:0]        settle_q;
  logic                 settled;

  assign raw     = {p2_btn, p1_btn, start};
  assign settled = (settle_q == SW'(SETTLE));

  // Counts edges since reset until the conditioning pipeline carries real input samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         settle_q <= '0;
    else if (!settled) settle_q <= settle_q + 1'b1;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_btn
`ifdef TUG_DEBOUNCE_EN
    tug_btn_cond #(.DB_CYC(DB_CYC)) u_btn (
`else
    tug_btn_cond u_btn (
`endif
      .clk      (clk),
      .rst      (reset),
      .btn_i    (raw[g]),
      .settled_i(settled),
      .press_o  (press[g])
    );
  end

  logic          start_p, p1_p, p2_p;
  logic [2:0]    state_q, state_d;
  logic [4:0]    pos_q, pos_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [5:0]    screen_q, screen_d;
  logic          tick_last;

  assign start_p   = press[0];
  assign p1_p      = press[1];
  assign p2_p      = press[2];
  assign tick_last = (tick_q == TW'(TICK_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    tick_d  = '0;
    case (state_q)
      S_IDLE, S_P1WIN, S_P2WIN: begin
        if (start_p) begin
          state_d = S_CNT3;
          pos_d   = 5'd23;
        end
      end
      S_CNT3: if (tick_last) state_d = S_CNT2; else tick_d = tick_q + 1'b1;
      S_CNT2: if (tick_last) state_d = S_CNT1; else tick_d = tick_q + 1'b1;
      S_CNT1: if (tick_last) state_d = S_GO;   else tick_d = tick_q + 1'b1;
      S_GO:   if (tick_last) state_d = S_PLAY; else tick_d = tick_q + 1'b1;
      S_PLAY: begin
        if (p1_p && !p2_p) begin
          pos_d = pos_q - 5'd1;
          if (pos_d == 5'd16) state_d = S_P1WIN;
        end else if (p2_p && !p1_p) begin
          pos_d = pos_q + 5'd1;
          if (pos_d == 5'd30) state_d = S_P2WIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Screen is decoded from next-state so it changes on the same edge as the state.
  always_comb begin
    screen_d = 6'd0;
    case (state_d)
      S_CNT3:  screen_d = 6'd34;
      S_CNT2:  screen_d = 6'd33;
      S_CNT1:  screen_d = 6'd32;
      S_GO:    screen_d = 6'd31;
      S_PLAY:  screen_d = {1'b0, pos_d};
      S_P1WIN: screen_d = 6'd16;
      S_P2WIN: screen_d = 6'd30;
      default: screen_d = 6'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pos_q    <= 5'd23;
      tick_q   <= '0;
      screen_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      tick_q   <= tick_d;
      screen_q <= screen_d;
    end
  end

  assign screen = screen_q;
endmodule

// File: tb/tb_tug_game_ctrl.sv
// Directed bench for tug_game_ctrl with TICK_CYCLES=10, DEBOUNCE_CYCLES=4.
module tb_tug_game_ctrl;
  localparam int TICK = 10;
  localparam int DBC  = 4;
`ifdef TUG_DEBOUNCE_EN
  localparam int LAT = 3 + DBC;
`else
  localparam int LAT = 3;
`endif
  localparam int SETTLE_W = 16;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       start  = 1'b0;
  logic       p1_btn = 1'b0;
  logic       p2_btn = 1'b0;
  logic [5:0] screen;

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  tug_game_ctrl #(.TICK_CYCLES(TICK), .DEBOUNCE_CYCLES(DBC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .p1_btn(p1_btn),
    .p2_btn(p2_btn),
    .screen(screen)
  );

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: screen=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic a, input logic b, input int hold);
    p1_btn = a;
    p2_btn = b;
    cyc(hold);
    p1_btn = 1'b0;
    p2_btn = 1'b0;
    cyc(SETTLE_W);
  endtask

  task automatic start_enter();
    start = 1'b1;
    cyc(LAT);
    chk("start_to_cnt3", screen, 6'd34);
    start = 1'b0;
  endtask

  logic [5:0] cd [4];

  initial begin
    cd = '{6'd34, 6'd33, 6'd32, 6'd31};
    cyc(2);
    chk("reset_state", screen, 6'd0);
    reset = 1'b0;
    cyc(2);

    // full countdown: each code for exactly TICK cycles
    start_enter();
    for (int i = 0; i < 4; i++) begin
      chk("cd_entry", screen, cd[i]);
      cyc(TICK - 1);
      chk("cd_last", screen, cd[i]);
      cyc(1);
    end
    chk("play_entry", screen, 6'd23);

    // press latency: no change one edge early, change on the LAT-th edge
    p1_btn = 1'b1;
    cyc(LAT - 1);
    chk("p1_lat_early", screen, 6'd23);
    cyc(1);
    chk("p1_lat_exact", screen, 6'd22);
    p1_btn = 1'b0;
    cyc(SETTLE_W);

    press(1'b1, 1'b1, 6);
    chk("both_same_cycle", screen, 6'd22);
    press(1'b0, 1'b1, 50);
    chk("p2_held_once", screen, 6'd23);
`ifdef TUG_DEBOUNCE_EN
    press(1'b0, 1'b1, 3);
    chk("p2_glitch", screen, 6'd23);
    press(1'b0, 1'b1, 6);
    chk("p2_pulse6", screen, 6'd24);
`else
    press(1'b0, 1'b1, 1);
    chk("p2_pulse1", screen, 6'd24);
`endif
    press(1'b1, 1'b0, 6);
    chk("p1_back", screen, 6'd23);

    for (int k = 1; k <= 7; k++) begin
      press(1'b1, 1'b0, 6);
      chk("p1_walk", screen, 6'(23 - k));
    end
    press(1'b1, 1'b0, 6);
    chk("p1win_p1_ignored", screen, 6'd16);
    press(1'b0, 1'b1, 6);
    chk("p1win_p2_ignored", screen, 6'd16);

    // restart from P1WIN; player presses in CNT2 and GO are ignored
    start_enter();
    cyc(12);
    p1_btn = 1'b1;
    cyc(6);
    p1_btn = 1'b0;
    chk("cnt2_press", screen, 6'd33);
    cyc(14);
    p1_btn = 1'b1;
    cyc(6);
    p1_btn = 1'b0;
    chk("go_press", screen, 6'd31);
    cyc(2);
    chk("play_after_ignored", screen, 6'd23);
    cyc(SETTLE_W);
    chk("play_stable", screen, 6'd23);

    for (int k = 1; k <= 4; k++) begin
      press(1'b0, 1'b1, 6);
      chk("p2_walk", screen, 6'(23 + k));
    end

    // asynchronous reset mid-game, start held through release
    #2;
    reset = 1'b1;
    start = 1'b1;
    #1;
    chk("async_reset", screen, 6'd0);
    cyc(2);
    reset = 1'b0;
    cyc(12);
    chk("start_held_thru_reset", screen, 6'd0);
    start = 1'b0;
    cyc(SETTLE_W);
    chk("idle_after_release", screen, 6'd0);
    press(1'b0, 1'b1, 6);
    chk("idle_p2_ignored", screen, 6'd0);
    start_enter();
    cyc(2);
    chk("cnt3_after_reset", screen, 6'd34);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
